trap_monitor: RTL and testbench

Synthesizable run-control and memory-dump block beside the processor core (toplevel). Counts cycles and retired instructions and halts on a configurable trap word or a cycle timeout. After halting, it walks data memory through a synchronous read port and streams every word out over a valid/ready interface, so the end-of-program handling previously done inside the bench lives in RTL and can be reused by FPGA and pipelined variants.

---
 rtl/trap_mon_pkg.sv | 20 ++
 rtl/trap_mon_dump_seq.sv | 87 ++++++++
 rtl/trap_monitor.sv | 84 ++++++++
 tb/tb_trap_monitor.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_mon_pkg.sv
// Shared types and constants for the trap monitor and its dump sequencer.
package trap_mon_pkg;

  typedef enum logic [2:0] {
    RUN,
    RD,
    CAP,
    OUT,
    DONE
  } state_e;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h44000300;
  localparam logic [31:0] SIG_INIT           = 32'hFFFFFFFF;

  // One signature step: rotate left by one, then fold in the dumped word.
  function automatic logic [31:0] sig_step(input logic [31:0] sig, input logic [31:0] word);
    return {sig[30:0], sig[31]} ^ word;
  endfunction

endpackage

// File: rtl/trap_mon_dump_seq.sv
// Post-halt memory walker: reads each word, presents it on a valid/ready port.
// Optional checksum register built only when TRAP_MONITOR_SIGNATURE_EN is defined.
module trap_mon_dump_seq
  import trap_mon_pkg::*;
#(
  parameter  int unsigned MEM_SIZE   = 1024,
  parameter  int unsigned DUMP_WIDTH = 8,
  localparam int unsigned AW         = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_rd_en,
  output logic [AW-1:0]         mem_rd_addr,
  input  logic [DUMP_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  output logic [AW-1:0]         out_addr,
  output logic [DUMP_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  done,
  output logic [31:0]           signature
);

  localparam logic [AW-1:0] LAST = AW'(MEM_SIZE - 1);

  state_e        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          hs_c;

  assign hs_c = (state == OUT) && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (start) state_nxt = RD;
      RD:      state_nxt = CAP;
      CAP:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = (ptr == LAST) ? DONE : RD;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  // Pointer advances on every handshake except the last word.
  always_comb begin
    ptr_nxt = ptr;
    if (hs_c && (ptr != LAST)) ptr_nxt = ptr + AW'(1);
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      done        <= 1'b0;
    end else begin
      ptr       <= ptr_nxt;
      mem_rd_en <= (state_nxt == RD);
      if (state_nxt == RD) mem_rd_addr <= ptr_nxt;
      out_valid <= (state_nxt == OUT);
      if (state == CAP) begin
        out_data <= mem_rd_data;
        out_addr <= ptr;
      end
      done <= (state_nxt == DONE);
    end
  end

`ifdef TRAP_MONITOR_SIGNATURE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      signature <= SIG_INIT;
    else if (hs_c) signature <= sig_step(signature, 32'(out_data));
  end
`else
  assign signature = 32'h0;
`endif

endmodule

// File: rtl/trap_monitor.sv
// Run control beside the core: counts cycles/instructions, halts on trap or
// timeout, then dumps data memory. Signature via TRAP_MONITOR_SIGNATURE_EN.
module trap_monitor
  import trap_mon_pkg::*;
#(
  parameter  int unsigned            INSTR_WIDTH = 32,
  parameter  logic [INSTR_WIDTH-1:0] HALT_INSTR  = INSTR_WIDTH'(HALT_INSTR_DEFAULT),
  parameter  int unsigned            MEM_SIZE    = 1024,
  parameter  int unsigned            DUMP_WIDTH  = 8,
  parameter  int unsigned            TIMEOUT     = 2500,
  parameter  int unsigned            CNT_WIDTH   = 32,
  localparam int unsigned            AW          = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [INSTR_WIDTH-1:0] pc,
  output logic                   halt_o,
  output logic                   timeout_o,
  output logic [INSTR_WIDTH-1:0] halt_pc,
  output logic [CNT_WIDTH-1:0]   cycle_count,
  output logic [CNT_WIDTH-1:0]   instr_count,
  output logic                   mem_rd_en,
  output logic [AW-1:0]          mem_rd_addr,
  input  logic [DUMP_WIDTH-1:0]  mem_rd_data,
  output logic                   out_valid,
  output logic [AW-1:0]          out_addr,
  output logic [DUMP_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic                   done,
  output logic [31:0]            signature
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

  logic run_c, trap_c, timeout_c;

  // halt_o low is exactly the RUN phase; the dump sequencer follows it.
  assign run_c     = !halt_o;
  assign trap_c    = run_c && instr_valid && (instr == HALT_INSTR);
  assign timeout_c = run_c && (TIMEOUT != 0) && (cycle_count == TO_LAST) && !trap_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_o      <= 1'b0;
      timeout_o   <= 1'b0;
      halt_pc     <= '0;
      cycle_count <= '0;
      instr_count <= '0;
    end else if (run_c) begin
      if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_WIDTH'(1);
      if (instr_valid && (instr_count != CNT_MAX)) instr_count <= instr_count + CNT_WIDTH'(1);
      if (trap_c) begin
        halt_o  <= 1'b1;
        halt_pc <= pc;
      end else if (timeout_c) begin
        halt_o    <= 1'b1;
        timeout_o <= 1'b1;
        halt_pc   <= '0;
      end
    end
  end

  trap_mon_dump_seq #(
    .MEM_SIZE   (MEM_SIZE),
    .DUMP_WIDTH (DUMP_WIDTH)
  ) u_dump (
    .clk         (clk),
    .rst         (rst),
    .start       (trap_c || timeout_c),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .done        (done),
    .signature   (signature)
  );

endmodule

// File: tb/tb_trap_monitor.sv
// Directed bench for trap_monitor: trap/timeout halt, dump stream, stall, reset.
module tb_trap_monitor;
  import trap_mon_pkg::*;

  localparam int unsigned MS = 4;
  localparam int unsigned AW = 2;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] TRAP = 32'h44000300;
`ifdef TRAP_MONITOR_SIGNATURE_EN
  localparam logic [31:0] SIG_RST = 32'hFFFFFFFF;
`else
  localparam logic [31:0] SIG_RST = 32'h0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          instr_valid = 1'b0;
  logic [31:0]   instr = '0;
  logic [31:0]   pc = '0;
  logic          halt_o, timeout_o;
  logic [31:0]   halt_pc, cycle_count, instr_count;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_data = '0;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [7:0]    out_data;
  logic          out_ready = 1'b1;
  logic          done;
  logic [31:0]   signature;

  logic [7:0]  mem [MS];
  logic [31:0] sig_model;
  int checks = 0;
  int errors = 0;

  trap_monitor #(
    .INSTR_WIDTH (32),
    .HALT_INSTR  (32'h44000300),
    .MEM_SIZE    (MS),
    .DUMP_WIDTH  (8),
    .TIMEOUT     (20),
    .CNT_WIDTH   (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .halt_o      (halt_o),
    .timeout_o   (timeout_o),
    .halt_pc     (halt_pc),
    .cycle_count (cycle_count),
    .instr_count (instr_count),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .done        (done),
    .signature   (signature)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory: data valid the cycle after the strobe.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  function automatic logic [31:0] sig_next(input logic [31:0] s, input logic [7:0] d);
`ifdef TRAP_MONITOR_SIGNATURE_EN
    return {s[30:0], s[31]} ^ {24'h0, d};
`else
    return s;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; instr_valid = 1'b0; instr = '0; pc = '0; out_ready = 1'b1;
    sig_model = SIG_RST;
    tick;
    tick;
    rst = 1'b1;
  endtask

  // Consume words until stop_at; stall_idx word is held off with out_ready=0 for 5 cycles.
  task automatic run_dump(input int stall_idx, input int stop_at);
    for (int i = 0; i < MS; i++) begin
      int n;
      if (i == stop_at) return;
      out_ready = (i != stall_idx);
      n = 0;
      while (!out_valid && n < 8) begin tick; n++; end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL dump_valid word %0d: out_valid=%b want 1", i, out_valid);
        out_ready = 1'b1;
        return;
      end
      checks++;
      if (out_addr !== AW'(i)) begin errors++; $display("FAIL dump_addr word %0d: got %0d want %0d", i, out_addr, i); end
      checks++;
      if (out_data !== mem[i]) begin errors++; $display("FAIL dump_data word %0d: got %h want %h", i, out_data, mem[i]); end
      if (i == stall_idx) begin
        for (int s = 0; s < 5; s++) begin
          tick;
          checks++;
          if (out_valid !== 1'b1 || out_addr !== AW'(i) || out_data !== mem[i] || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cyc %0d: valid=%b addr=%0d data=%h rd_en=%b want 1 %0d %h 0",
                     s, out_valid, out_addr, out_data, mem_rd_en, i, mem[i]);
          end
        end
        out_ready = 1'b1;
      end
      sig_model = sig_next(sig_model, mem[i]);
      tick;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL valid_drop word %0d: out_valid=%b want 0", i, out_valid); end
      if (i < MS - 1) begin
        checks++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr !== AW'(i + 1)) begin
          errors++; $display("FAIL next_rd word %0d: rd_en=%b addr=%0d want 1 %0d", i, mem_rd_en, mem_rd_addr, i + 1);
        end
      end else begin
        checks++;
        if (done !== 1'b1 || halt_o !== 1'b1) begin
          errors++; $display("FAIL done_after_last: done=%b halt_o=%b want 1 1", done, halt_o);
        end
        checks++;
        if (signature !== sig_model) begin
          errors++; $display("FAIL signature: got %h want %h", signature, sig_model);
        end
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; sig_model = SIG_RST;
    #2;
    checks++;
    if (halt_o !== 1'b0 || timeout_o !== 1'b0 || halt_pc !== 32'h0 || cycle_count !== 32'h0 ||
        instr_count !== 32'h0 || mem_rd_en !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: halt=%b to=%b pc=%h cyc=%0d ins=%0d rd=%b ov=%b done=%b want all 0",
               halt_o, timeout_o, halt_pc, cycle_count, instr_count, mem_rd_en, out_valid, done);
    end
    checks++;
    if (signature !== SIG_RST) begin errors++; $display("FAIL reset_sig: got %h want %h", signature, SIG_RST); end
  endtask

  task automatic test_trap;
    do_reset;
    instr_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      instr = NOP; pc = 32'(4 * k);
      tick;
    end
    instr = TRAP; pc = 32'h14;
    checks++;
    if (halt_o !== 1'b0) begin errors++; $display("FAIL trap_pre_halt: halt_o=%b want 0", halt_o); end
    tick;
    instr = NOP;
    checks++;
    if (halt_o !== 1'b1 || halt_pc !== 32'h14 || timeout_o !== 1'b0) begin
      errors++; $display("FAIL trap_halt: halt=%b pc=%h to=%b want 1 00000014 0", halt_o, halt_pc, timeout_o);
    end
    checks++;
    if (instr_count !== 32'd5 || cycle_count !== 32'd5) begin
      errors++; $display("FAIL trap_counts: ins=%0d cyc=%0d want 5 5", instr_count, cycle_count);
    end
    checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== AW'(0) || out_valid !== 1'b0) begin
      errors++; $display("FAIL trap_rd: rd=%b addr=%0d ov=%b want 1 0 0", mem_rd_en, mem_rd_addr, out_valid);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0 || mem_rd_en !== 1'b0 || instr_count !== 32'd5 || cycle_count !== 32'd5) begin
      errors++; $display("FAIL trap_cap: ov=%b rd=%b ins=%0d cyc=%0d want 0 0 5 5", out_valid, mem_rd_en, instr_count, cycle_count);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid_latency: out_valid=%b want 1", out_valid); end
    run_dump(-1, MS);
    instr_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick;
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || halt_o !== 1'b1) begin
      errors++; $display("FAIL done_hold: done=%b ov=%b halt=%b want 1 0 1", done, out_valid, halt_o);
    end
  endtask

  task automatic test_timeout;
    do_reset;
    for (int k = 0; k < 19; k++) tick;
    checks++;
    if (halt_o !== 1'b0 || cycle_count !== 32'd19) begin
      errors++; $display("FAIL timeout_pre: halt=%b cyc=%0d want 0 19", halt_o, cycle_count);
    end
    tick;
    checks++;
    if (halt_o !== 1'b1 || timeout_o !== 1'b1 || halt_pc !== 32'h0) begin
      errors++; $display("FAIL timeout_halt: halt=%b to=%b pc=%h want 1 1 0", halt_o, timeout_o, halt_pc);
    end
    checks++;
    if (cycle_count !== 32'd20 || instr_count !== 32'd0) begin
      errors++; $display("FAIL timeout_counts: cyc=%0d ins=%0d want 20 0", cycle_count, instr_count);
    end
    run_dump(2, MS);
    checks++;
    if (cycle_count !== 32'd20 || timeout_o !== 1'b1) begin
      errors++; $display("FAIL timeout_freeze: cyc=%0d to=%b want 20 1", cycle_count, timeout_o);
    end
  endtask

  task automatic test_trap_at_timeout;
    do_reset;
    instr_valid = 1'b1; instr = NOP;
    for (int k = 0; k < 19; k++) tick;
    instr = TRAP; pc = 32'h4C;
    tick;
    instr_valid = 1'b0;
    checks++;
    if (halt_o !== 1'b1 || timeout_o !== 1'b0 || halt_pc !== 32'h4C) begin
      errors++; $display("FAIL trap_wins: halt=%b to=%b pc=%h want 1 0 0000004c", halt_o, timeout_o, halt_pc);
    end
    checks++;
    if (instr_count !== 32'd20 || cycle_count !== 32'd20) begin
      errors++; $display("FAIL trap_wins_counts: ins=%0d cyc=%0d want 20 20", instr_count, cycle_count);
    end
  endtask

  task automatic test_reset_mid_dump;
    do_reset;
    instr_valid = 1'b1; instr = TRAP; pc = 32'h100;
    tick;
    instr_valid = 1'b0;
    run_dump(-1, 2);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (halt_o !== 1'b0 || timeout_o !== 1'b0 || halt_pc !== 32'h0 || cycle_count !== 32'h0 ||
        instr_count !== 32'h0 || mem_rd_en !== 1'b0 || mem_rd_addr !== AW'(0) || out_valid !== 1'b0 ||
        out_addr !== AW'(0) || out_data !== 8'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: halt=%b pc=%h cyc=%0d ins=%0d rd=%b ra=%0d ov=%b oa=%0d od=%h done=%b want all 0",
               halt_o, halt_pc, cycle_count, instr_count, mem_rd_en, mem_rd_addr, out_valid, out_addr, out_data, done);
    end
    checks++;
    if (signature !== SIG_RST) begin errors++; $display("FAIL async_reset_sig: got %h want %h", signature, SIG_RST); end
    sig_model = SIG_RST;
    tick;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) tick;
    checks++;
    if (halt_o !== 1'b0 || cycle_count !== 32'd3 || mem_rd_en !== 1'b0) begin
      errors++; $display("FAIL restart_run: halt=%b cyc=%0d rd=%b want 0 3 0", halt_o, cycle_count, mem_rd_en);
    end
    instr_valid = 1'b1; instr = TRAP; pc = 32'h200;
    tick;
    instr_valid = 1'b0;
    checks++;
    if (halt_o !== 1'b1 || halt_pc !== 32'h200 || instr_count !== 32'd1 || mem_rd_addr !== AW'(0)) begin
      errors++; $display("FAIL restart_trap: halt=%b pc=%h ins=%0d ra=%0d want 1 00000200 1 0", halt_o, halt_pc, instr_count, mem_rd_addr);
    end
    run_dump(-1, MS);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
    test_reset;
    test_trap;
    test_timeout;
    test_trap_at_timeout;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h5A; mem[3] = 8'h80;
    test_reset_mid_dump;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
